// File: rtl/mc_phase_sequencer.sv
// mc_phase_sequencer: multicycle MIPS phase sequencer. Decodes opcode/funct in
// ID into an instruction-class path (IF, ID, EX, optional MEM, optional WB),
// emits registered one-cycle phase pulses on state entry, handles memory wait
// states with timeout abort, a global stall, illegal-opcode trapping and a
// retired-instruction counter.
module mc_phase_sequencer #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               stall,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               IF_signal,
  output logic               ID_signal,
  output logic               EX_signal,
  output logic               MEM_signal,
  output logic               WB_signal,
  output logic [3:0]         state,
  output logic               illegal,
  output logic               bus_err,
  output logic [CNT_W-1:0]   retired
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_INI    = 4'd0,
    S_IF     = 4'd1,
    S_ID     = 4'd2,
    S_EX_RI  = 4'd3,
    S_EX_LS  = 4'd4,
    S_EX_BR  = 4'd5,
    S_EX_JMP = 4'd6,
    S_MEM_L  = 4'd7,
    S_MEM_S  = 4'd8,
    S_WB_R   = 4'd9,
    S_WB_L   = 4'd10
  } state_e;

  state_e             state_q, state_d;
  logic               is_load_q, is_load_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               if_q, if_d;
  logic               id_q, id_d;
  logic               ex_q, ex_d;
  logic               mem_q, mem_d;
  logic               wb_q, wb_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;

  logic               abort;
  logic               ill;
  logic               retire;
  logic               entered;
  logic               timeout_hit;
  logic [5:0]         op6;
  logic [5:0]         fn6;

  // Decode operates on the 6-bit MIPS field layout.
  assign op6 = 6'(op);
  assign fn6 = 6'(funct);

  // Wait budget is exhausted when this non-ready cycle would be the TIMEOUT-th.
  assign timeout_hit = (TIMEOUT != 0) && !mem_ready &&
                       (32'(wait_q) == TIMEOUT - 32'd1);

  // State, counters and registered outputs; reset takes effect asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INI;
      is_load_q <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
      if_q      <= 1'b0;
      id_q      <= 1'b0;
      ex_q      <= 1'b0;
      mem_q     <= 1'b0;
      wb_q      <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      if_q      <= if_d;
      id_q      <= id_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic: decode in ID, ready/timeout handling in IF and MEM.
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    abort     = 1'b0;
    ill       = 1'b0;
    retire    = 1'b0;
    if (!stall) begin
      case (state_q)
        S_INI: state_d = S_IF;
        S_IF: begin
          if (mem_ready)        state_d = S_ID;
          else if (timeout_hit) abort   = 1'b1;
        end
        S_ID: begin
          if (op6 == 6'b000000) begin
            state_d = (fn6 == 6'b001000 || fn6 == 6'b001001) ? S_EX_JMP : S_EX_RI;
          end else if (op6[5:3] == 3'b001) begin
            state_d = S_EX_RI;
          end else if (op6 inside {6'b000001, 6'b000100, 6'b000101,
                                   6'b000110, 6'b000111}) begin
            state_d = S_EX_BR;
          end else if (op6 inside {6'b000010, 6'b000011}) begin
            state_d = S_EX_JMP;
          end else if (op6 inside {6'b100000, 6'b100001, 6'b100011,
                                   6'b100100, 6'b100101}) begin
            state_d   = S_EX_LS;
            is_load_d = 1'b1;
          end else if (op6 inside {6'b101000, 6'b101001, 6'b101011}) begin
            state_d   = S_EX_LS;
            is_load_d = 1'b0;
          end else begin
            ill     = 1'b1;
            state_d = S_IF;
          end
        end
        S_EX_RI: state_d = S_WB_R;
        S_EX_LS: state_d = is_load_q ? S_MEM_L : S_MEM_S;
        S_EX_BR, S_EX_JMP, S_WB_R, S_WB_L: begin
          state_d = S_IF;
          retire  = 1'b1;
        end
        S_MEM_L: begin
          if (mem_ready)        state_d = S_WB_L;
          else if (timeout_hit) abort   = 1'b1;
        end
        S_MEM_S: begin
          if (mem_ready) begin
            state_d = S_IF;
            retire  = 1'b1;
          end else if (timeout_hit) begin
            abort = 1'b1;
          end
        end
        default: state_d = S_INI;
      endcase
      if (abort) state_d = S_IF;
    end
  end

  // Output/next-value logic: entry pulses, wait counter, retired count, mem_req.
  always_comb begin
    // An abort re-enters IF from IF, so it counts as an entry too.
    entered   = (state_d != state_q) || abort;
    if_d      = entered && (state_d == S_IF);
    id_d      = entered && (state_d == S_ID);
    ex_d      = entered && (state_d inside {S_EX_RI, S_EX_LS, S_EX_BR, S_EX_JMP});
    mem_d     = entered && (state_d inside {S_MEM_L, S_MEM_S});
    wb_d      = entered && (state_d inside {S_WB_R, S_WB_L});
    illegal_d = ill;
    bus_err_d = abort;
    retired_d = retired_q + CNT_W'(retire);
    mem_req   = (state_q inside {S_IF, S_MEM_L, S_MEM_S});
    if (entered)                          wait_d = '0;
    else if (!stall && !mem_ready && mem_req) wait_d = wait_q + WAIT_W'(1);
    else                                  wait_d = wait_q;
  end

  assign state      = state_q;
  assign IF_signal  = if_q;
  assign ID_signal  = id_q;
  assign EX_signal  = ex_q;
  assign MEM_signal = mem_q;
  assign WB_signal  = wb_q;
  assign illegal    = illegal_q;
  assign bus_err    = bus_err_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mc_phase_sequencer.sv
// Directed bench for mc_phase_sequencer (TIMEOUT=4, CNT_W=4) with
// hand-computed per-cycle state/pulse expectations.
module tb_mc_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       stall;
  logic       mem_ready;
  logic       mem_req;
  logic       IF_signal, ID_signal, EX_signal, MEM_signal, WB_signal;
  logic [3:0] state;
  logic       illegal, bus_err;
  logic [3:0] retired;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // pulse vector layout: {IF, ID, EX, MEM, WB, illegal, bus_err}
  localparam logic [6:0] P_0   = 7'b0000000;
  localparam logic [6:0] P_IF  = 7'b1000000;
  localparam logic [6:0] P_ID  = 7'b0100000;
  localparam logic [6:0] P_EX  = 7'b0010000;
  localparam logic [6:0] P_MEM = 7'b0001000;
  localparam logic [6:0] P_WB  = 7'b0000100;
  localparam logic [6:0] P_ILL = 7'b0000010;
  localparam logic [6:0] P_BE  = 7'b0000001;

  mc_phase_sequencer #(
    .OP_W    (6),
    .FUNCT_W (6),
    .TIMEOUT (4),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .stall      (stall),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .IF_signal  (IF_signal),
    .ID_signal  (ID_signal),
    .EX_signal  (EX_signal),
    .MEM_signal (MEM_signal),
    .WB_signal  (WB_signal),
    .state      (state),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check state, mem_req (decoded from expected state) and the pulse vector.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [6:0] pul);
    logic exp_req;
    exp_req = (st == 4'd1) || (st == 4'd7) || (st == 4'd8);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".mem_req"}, 32'(mem_req), 32'(exp_req));
    chk({tag, ".pulses"},
        32'({IF_signal, ID_signal, EX_signal, MEM_signal, WB_signal, illegal, bus_err}),
        32'(pul));
  endtask

  initial begin
    rst = 1'b1; op = 6'b000000; funct = 6'b100001; stall = 1'b0; mem_ready = 1'b1;
    #1;
    cyc("reset", 4'd0, P_0);
    chk("reset.retired", 32'(retired), 32'd0);
    #11 rst = 1'b0;

    // R-type ADDU: IF, ID, EX_RI, WB_R, IF
    tick(); cyc("r.if", 4'd1, P_IF);
    tick(); cyc("r.id", 4'd2, P_ID);
    tick(); cyc("r.ex", 4'd3, P_EX);
    tick(); cyc("r.wb", 4'd9, P_WB);
    chk("r.ret0", 32'(retired), 32'd0);
    tick(); cyc("r.if2", 4'd1, P_IF);
    chk("r.ret1", 32'(retired), 32'd1);

    // LW with three not-ready MEM_L cycles: 8 cycles total
    op = 6'b100011;
    tick(); cyc("lw.id", 4'd2, P_ID);
    tick(); cyc("lw.ex", 4'd4, P_EX);
    tick(); cyc("lw.mem1", 4'd7, P_MEM);
    mem_ready = 1'b0;
    tick(); cyc("lw.mem2", 4'd7, P_0);
    tick(); cyc("lw.mem3", 4'd7, P_0);
    tick(); cyc("lw.mem4", 4'd7, P_0);
    mem_ready = 1'b1;
    tick(); cyc("lw.wb", 4'd10, P_WB);
    chk("lw.ret_hold", 32'(retired), 32'd1);
    tick(); cyc("lw.if", 4'd1, P_IF);
    chk("lw.ret", 32'(retired), 32'd2);

    // Illegal opcode, then ADDI
    op = 6'b111111;
    tick(); cyc("ill.id", 4'd2, P_ID);
    tick(); cyc("ill.if", 4'd1, P_IF | P_ILL);
    chk("ill.ret", 32'(retired), 32'd2);
    op = 6'b001000;
    tick(); cyc("addi.id", 4'd2, P_ID);
    tick(); cyc("addi.ex", 4'd3, P_EX);
    tick(); cyc("addi.wb", 4'd9, P_WB);
    tick(); cyc("addi.if", 4'd1, P_IF);
    chk("addi.ret", 32'(retired), 32'd3);

    // BEQ, JR, SW
    op = 6'b000100;
    tick(); cyc("beq.id", 4'd2, P_ID);
    tick(); cyc("beq.ex", 4'd5, P_EX);
    tick(); cyc("beq.if", 4'd1, P_IF);
    chk("beq.ret", 32'(retired), 32'd4);
    op = 6'b000000; funct = 6'b001000;
    tick(); cyc("jr.id", 4'd2, P_ID);
    tick(); cyc("jr.ex", 4'd6, P_EX);
    tick(); cyc("jr.if", 4'd1, P_IF);
    chk("jr.ret", 32'(retired), 32'd5);
    op = 6'b101011;
    tick(); cyc("sw.id", 4'd2, P_ID);
    tick(); cyc("sw.ex", 4'd4, P_EX);
    tick(); cyc("sw.mem", 4'd8, P_MEM);
    tick(); cyc("sw.if", 4'd1, P_IF);
    chk("sw.ret", 32'(retired), 32'd6);

    // IF timeout: abort on the 4th not-ready edge
    mem_ready = 1'b0;
    tick(); cyc("to.w1", 4'd1, P_0);
    tick(); cyc("to.w2", 4'd1, P_0);
    tick(); cyc("to.w3", 4'd1, P_0);
    tick(); cyc("to.abort", 4'd1, P_IF | P_BE);
    chk("to.ret", 32'(retired), 32'd6);
    // Ready arrives on the 4th edge: normal transition wins
    tick(); cyc("tr.w1", 4'd1, P_0);
    tick(); cyc("tr.w2", 4'd1, P_0);
    tick(); cyc("tr.w3", 4'd1, P_0);
    mem_ready = 1'b1;
    op = 6'b000010;
    tick(); cyc("tr.id", 4'd2, P_ID);
    tick(); cyc("tr.ex", 4'd6, P_EX);
    tick(); cyc("tr.if", 4'd1, P_IF);
    chk("tr.ret", 32'(retired), 32'd7);

    // Stall for 2 edges just before ID entry, then 1 edge inside ID
    op = 6'b000000; funct = 6'b100001;
    stall = 1'b1;
    tick(); cyc("st.h1", 4'd1, P_0);
    tick(); cyc("st.h2", 4'd1, P_0);
    chk("st.ret_hold", 32'(retired), 32'd7);
    stall = 1'b0;
    tick(); cyc("st.id", 4'd2, P_ID);
    stall = 1'b1;
    tick(); cyc("st.idh", 4'd2, P_0);
    stall = 1'b0;
    tick(); cyc("st.ex", 4'd3, P_EX);
    tick(); cyc("st.wb", 4'd9, P_WB);
    tick(); cyc("st.if", 4'd1, P_IF);
    chk("st.ret", 32'(retired), 32'd8);

    // Asynchronous reset in the middle of an SB wait
    op = 6'b101000;
    tick(); cyc("sb.id", 4'd2, P_ID);
    tick(); cyc("sb.ex", 4'd4, P_EX);
    tick(); cyc("sb.mem", 4'd8, P_MEM);
    mem_ready = 1'b0;
    tick(); cyc("sb.wait", 4'd8, P_0);
    #2 rst = 1'b1;
    #1;
    cyc("arst", 4'd0, P_0);
    chk("arst.retired", 32'(retired), 32'd0);
    #2 rst = 1'b0; mem_ready = 1'b1;
    tick(); cyc("rs.if", 4'd1, P_IF);

    // Retired counter wraps at 16 (JAL, 3 cycles each)
    op = 6'b000011;
    for (int i = 0; i < 16; i++) begin
      tick();
      tick();
      tick();
      chk($sformatf("wrap.ret%0d", i), 32'(retired), 32'((i + 1) % 16));
    end
    cyc("wrap.if", 4'd1, P_IF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
